// File: rtl/vx_mask_serializer_if.sv
// Handshake bundle for vx_mask_serializer: mask-in channel and one-hot beat-out channel.
// The master side issues masks and grants ready_out. The slave side is the serializer.
interface vx_mask_serializer_if #(
  parameter int N  = 4,
  parameter int LN = (N > 1) ? $clog2(N) : 1
);
  logic          valid_in;
  logic [N-1:0]  data_in;
  logic          ready_in;
  logic          valid_out;
  logic [N-1:0]  onehot_out;
  logic [LN-1:0] index_out;
  logic          last_out;
  logic          ready_out;

  modport master (
    output valid_in, data_in, ready_out,
    input  ready_in, valid_out, onehot_out, index_out, last_out
  );

  modport slave (
    input  valid_in, data_in, ready_out,
    output ready_in, valid_out, onehot_out, index_out, last_out
  );
endinterface

// File: rtl/vx_mask_serializer.sv
// Serializes a request mask into one-hot beats, lowest (or highest) set bit first.
// A new mask can be accepted in the same cycle as the last beat's handshake.
module vx_mask_serializer #(
  parameter int N       = 4,
  parameter bit REVERSE = 1'b0,
  parameter int LN      = (N > 1) ? $clog2(N) : 1
) (
  input logic                clk,
  input logic                reset,
  vx_mask_serializer_if.slave bus
);

  typedef enum logic {IDLE, BUSY} state_e;

  state_e        state_q, state_d;
  logic [N-1:0]  pend_q, pend_d;
  logic [N-1:0]  sel_oh;
  logic [LN-1:0] sel_idx;
  logic          busy, single, fire, accept;
  logic          ready_in, valid_out, last_out;

  // The loop direction sets priority: the last matching iteration wins.
  always_comb begin
    // NOTE: every always_comb output gets a default first, so no path leaves it unassigned (no latch).
    sel_oh  = '0;
    sel_idx = '0;
    if (REVERSE) begin
      for (int i = 0; i < N; i++) begin
        if (pend_q[i]) begin
          sel_oh    = '0;
          sel_oh[i] = 1'b1;
          sel_idx   = LN'(i);
        end
      end
    end else begin
      for (int i = N - 1; i >= 0; i--) begin
        if (pend_q[i]) begin
          sel_oh    = '0;
          sel_oh[i] = 1'b1;
          sel_idx   = LN'(i);
        end
      end
    end
  end

  assign busy      = (state_q == BUSY) && !reset;
  assign single    = (pend_q & (pend_q - N'(1))) == '0;
  assign valid_out = busy;
  assign last_out  = busy && single;
  assign fire      = valid_out && bus.ready_out;
  assign ready_in  = !reset && ((state_q == IDLE) || (fire && last_out));
  assign accept    = bus.valid_in && ready_in;

  assign bus.ready_in   = ready_in;
  assign bus.valid_out  = valid_out;
  assign bus.onehot_out = busy ? sel_oh : '0;
  assign bus.index_out  = busy ? sel_idx : '0;
  assign bus.last_out   = last_out;

  // A zero mask is accepted but leaves the retirement decision above untouched.
  always_comb begin
    state_d = state_q;
    pend_d  = pend_q;
    if (fire) begin
      pend_d = pend_q & ~sel_oh;
      if (last_out) state_d = IDLE;
    end
    if (accept && (bus.data_in != '0)) begin
      pend_d  = bus.data_in;
      state_d = BUSY;
    end
  end

  always_ff @(posedge clk) begin
    // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
    if (reset) begin
      state_q <= IDLE;
      pend_q  <= '0;
    end else begin
      state_q <= state_d;
      pend_q  <= pend_d;
    end
  end

  a_onehot: assert property (@(posedge clk) disable iff (reset)
    bus.valid_out |-> $onehot(bus.onehot_out));

endmodule

// File: tb/tb_vx_mask_serializer.sv
// Scoreboard bench: stimulus pushes hand-computed beats; a negedge monitor pops and compares.
// Two instances (REVERSE=0 and REVERSE=1) see identical stimulus.
module tb_vx_mask_serializer;

  typedef struct packed {
    logic [3:0] oh;
    logic [1:0] idx;
    logic       last;
  } beat_t;

  logic clk = 1'b0;
  logic reset;
  int   checks = 0;
  int   errors = 0;
  beat_t q0[$];
  beat_t q1[$];

  vx_mask_serializer_if #(.N(4)) b0 ();
  vx_mask_serializer_if #(.N(4)) b1 ();

  assign b1.valid_in  = b0.valid_in;
  assign b1.data_in   = b0.data_in;
  assign b1.ready_out = b0.ready_out;

  vx_mask_serializer #(.N(4), .REVERSE(1'b0)) dut0 (.clk(clk), .reset(reset), .bus(b0));
  vx_mask_serializer #(.N(4), .REVERSE(1'b1)) dut1 (.clk(clk), .reset(reset), .bus(b1));

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  task automatic pop_check(input int which, input beat_t act);
    beat_t e;
    int    have;
    if (which == 0) have = q0.size();
    else            have = q1.size();
    if (have == 0) begin
      checks++;
      errors++;
      $display("FAIL dut%0d_unexpected_beat actual=%0h expected=none", which, act);
    end else begin
      if (which == 0) e = q0.pop_front();
      else            e = q1.pop_front();
      check($sformatf("dut%0d_onehot", which), 32'(act.oh),   32'(e.oh));
      check($sformatf("dut%0d_index", which),  32'(act.idx),  32'(e.idx));
      check($sformatf("dut%0d_last", which),   32'(act.last), 32'(e.last));
    end
  endtask

  always @(negedge clk) begin
    if (b0.valid_out && b0.ready_out)
      pop_check(0, '{oh: b0.onehot_out, idx: b0.index_out, last: b0.last_out});
    if (b1.valid_out && b1.ready_out)
      pop_check(1, '{oh: b1.onehot_out, idx: b1.index_out, last: b1.last_out});
  end

  task automatic send(input logic [3:0] m);
    int n = 0;
    b0.valid_in = 1'b1;
    b0.data_in  = m;
    @(negedge clk);
    while (!b0.ready_in && n < 50) begin
      @(negedge clk);
      n++;
    end
    check("accept_ready_in", 32'(b0.ready_in), 32'd1);
    @(posedge clk);
    #1;
    b0.valid_in = 1'b0;
    b0.data_in  = 4'($urandom);
  endtask

  task automatic drain();
    int n = 0;
    while ((q0.size() + q1.size()) != 0 && n < 50) begin
      @(negedge clk);
      n++;
    end
    check("drain_queues_empty", 32'(q0.size() + q1.size()), 32'd0);
    @(posedge clk);
    #1;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog actual=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    reset        = 1'b1;
    b0.valid_in  = 1'b1;
    b0.data_in   = 4'b1111;
    b0.ready_out = 1'b1;

    // Outputs forced quiet while reset is held.
    @(negedge clk);
    check("rst_ready_in",   32'(b0.ready_in),   32'd0);
    check("rst_valid_out",  32'(b0.valid_out),  32'd0);
    check("rst_onehot",     32'(b0.onehot_out), 32'd0);
    check("rst_index",      32'(b0.index_out),  32'd0);
    check("rst_last",       32'(b0.last_out),   32'd0);
    check("rst_valid_out1", 32'(b1.valid_out),  32'd0);
    @(posedge clk);
    #1;
    reset       = 1'b0;
    b0.valid_in = 1'b0;
    @(negedge clk);
    check("idle_ready_in",  32'(b0.ready_in),  32'd1);
    check("idle_valid_out", 32'(b0.valid_out), 32'd0);
    @(posedge clk);
    #1;

    // Mask 1011 at full rate.
    q0.push_back('{oh: 4'b0001, idx: 2'd0, last: 1'b0});
    q0.push_back('{oh: 4'b0010, idx: 2'd1, last: 1'b0});
    q0.push_back('{oh: 4'b1000, idx: 2'd3, last: 1'b1});
    q1.push_back('{oh: 4'b1000, idx: 2'd3, last: 1'b0});
    q1.push_back('{oh: 4'b0010, idx: 2'd1, last: 1'b0});
    q1.push_back('{oh: 4'b0001, idx: 2'd0, last: 1'b1});
    send(4'b1011);
    check("latency_valid_out", 32'(b0.valid_out), 32'd1);
    drain();

    // Mask 1011 with beat 2 stalled for three cycles.
    q0.push_back('{oh: 4'b0001, idx: 2'd0, last: 1'b0});
    q0.push_back('{oh: 4'b0010, idx: 2'd1, last: 1'b0});
    q0.push_back('{oh: 4'b1000, idx: 2'd3, last: 1'b1});
    q1.push_back('{oh: 4'b1000, idx: 2'd3, last: 1'b0});
    q1.push_back('{oh: 4'b0010, idx: 2'd1, last: 1'b0});
    q1.push_back('{oh: 4'b0001, idx: 2'd0, last: 1'b1});
    send(4'b1011);
    @(posedge clk);
    #1;
    b0.ready_out = 1'b0;
    repeat (3) begin
      @(negedge clk);
      check("stall_valid_out", 32'(b0.valid_out),  32'd1);
      check("stall_onehot",    32'(b0.onehot_out), 32'b0010);
      check("stall_index",     32'(b0.index_out),  32'd1);
      check("stall_last",      32'(b0.last_out),   32'd0);
      check("stall_ready_in",  32'(b0.ready_in),   32'd0);
      check("stall_onehot1",   32'(b1.onehot_out), 32'b0010);
      @(posedge clk);
      #1;
    end
    b0.ready_out = 1'b1;
    drain();

    // Back-to-back masks 0110 then 1000 with no bubble.
    q0.push_back('{oh: 4'b0010, idx: 2'd1, last: 1'b0});
    q0.push_back('{oh: 4'b0100, idx: 2'd2, last: 1'b1});
    q0.push_back('{oh: 4'b1000, idx: 2'd3, last: 1'b1});
    q1.push_back('{oh: 4'b0100, idx: 2'd2, last: 1'b0});
    q1.push_back('{oh: 4'b0010, idx: 2'd1, last: 1'b1});
    q1.push_back('{oh: 4'b1000, idx: 2'd3, last: 1'b1});
    b0.valid_in = 1'b1;
    b0.data_in  = 4'b0110;
    @(negedge clk);
    check("b2b_accept0", 32'(b0.ready_in), 32'd1);
    @(posedge clk);
    #1;
    b0.data_in = 4'b1000;
    @(negedge clk);
    check("b2b_idx_a",      32'(b0.index_out), 32'd1);
    check("b2b_ready_a",    32'(b0.ready_in),  32'd0);
    check("b2b_idx_a_rev",  32'(b1.index_out), 32'd2);
    @(posedge clk);
    #1;
    @(negedge clk);
    check("b2b_idx_b",      32'(b0.index_out), 32'd2);
    check("b2b_ready_b",    32'(b0.ready_in),  32'd1);
    check("b2b_idx_b_rev",  32'(b1.index_out), 32'd1);
    @(posedge clk);
    #1;
    b0.valid_in = 1'b0;
    @(negedge clk);
    check("b2b_valid_c",    32'(b0.valid_out), 32'd1);
    check("b2b_idx_c",      32'(b0.index_out), 32'd3);
    check("b2b_idx_c_rev",  32'(b1.index_out), 32'd3);
    @(posedge clk);
    #1;
    drain();

    // All-zero mask is consumed without producing a beat.
    send(4'b0000);
    repeat (3) begin
      @(negedge clk);
      check("zero_valid_out",  32'(b0.valid_out), 32'd0);
      check("zero_valid_out1", 32'(b1.valid_out), 32'd0);
    end
    @(posedge clk);
    #1;

    // Reset during the second beat of 1111 discards the rest.
    q0.push_back('{oh: 4'b0001, idx: 2'd0, last: 1'b0});
    q1.push_back('{oh: 4'b1000, idx: 2'd3, last: 1'b0});
    send(4'b1111);
    @(posedge clk);
    #1;
    reset = 1'b1;
    @(negedge clk);
    check("midrst_valid_out", 32'(b0.valid_out),  32'd0);
    check("midrst_ready_in",  32'(b0.ready_in),   32'd0);
    check("midrst_onehot",    32'(b0.onehot_out), 32'd0);
    @(posedge clk);
    #1;
    reset = 1'b0;
    repeat (5) begin
      @(negedge clk);
      check("postrst_valid_out",  32'(b0.valid_out), 32'd0);
      check("postrst_valid_out1", 32'(b1.valid_out), 32'd0);
    end
    check("postrst_queues", 32'(q0.size() + q1.size()), 32'd0);
    @(posedge clk);
    #1;

    // Recovery: a fresh single-bit mask after reset.
    q0.push_back('{oh: 4'b0100, idx: 2'd2, last: 1'b1});
    q1.push_back('{oh: 4'b0100, idx: 2'd2, last: 1'b1});
    send(4'b0100);
    drain();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/vx_mask_serializer.md
VX_MASK_SERIALIZER -- requirements
Module: VX_mask_serializer

Interface
REQ-001 SHALL have parameter N, default 4, giving the request mask width in bits (N >= 1).
REQ-002 SHALL have parameter REVERSE, default 0: 0 serializes the lowest set bit first; 1 serializes the highest set bit first.
REQ-003 SHALL have parameter LN, default `LOG2UP(N), giving the index width.
REQ-004 SHALL have port clk, input, 1, the single clock; all state updates on its rising edge.
REQ-005 SHALL have port reset, input, 1, synchronous active-high reset.
REQ-006 SHALL have port valid_in, input, 1, upstream mask valid.
REQ-007 SHALL have port data_in, input, N, upstream request mask.
REQ-008 SHALL have port ready_in, output, 1, the block accepts the mask this cycle.
REQ-009 SHALL have port valid_out, output, 1, a one-hot beat is presented.
REQ-010 SHALL have port onehot_out, output, N, the selected bit as a one-hot vector.
REQ-011 SHALL have port index_out, output, LN, the absolute bit position of onehot_out, independent of REVERSE.
REQ-012 SHALL have port last_out, output, 1, this beat is the final set bit of the current mask.
REQ-013 SHALL have port ready_out, input, 1, downstream accepts the beat.

Function
REQ-014 SHALL implement two states, IDLE and BUSY, and a pending-mask register pend[N-1:0].
REQ-015 SHALL drive ready_in = (state == IDLE) || (valid_out && ready_out && last_out), so the block can accept a mask in the same cycle as the last beat handshake.
REQ-016 SHALL load pend <= data_in and enter or stay in BUSY when valid_in && ready_in && (data_in != 0).
REQ-017 SHALL consume and drop an all-zero mask, producing no beat and leaving the state unchanged if IDLE, or going to IDLE if the acceptance coincides with a last beat.
REQ-018 SHALL drive valid_out = 1 only in BUSY, and valid_out = 0 in IDLE.
REQ-019 SHALL drive onehot_out to the lowest set bit of pend if REVERSE == 0, or the highest if REVERSE == 1; onehot_out is 0 in IDLE.
REQ-020 SHALL drive index_out to the bit position of onehot_out, and to 0 in IDLE.
REQ-021 SHALL drive last_out = 1 when pend has exactly one bit set while in BUSY, and 0 otherwise.
REQ-022 SHALL clear the presented bit in pend on valid_out && ready_out, and go to IDLE after the last beat unless a new nonzero mask is accepted in the same cycle.
REQ-023 SHALL hold onehot_out, index_out, last_out and pend stable while valid_out && !ready_out.
REQ-024 SHALL ignore data_in changes when not accepted, since the mask is captured at acceptance.
REQ-025 SHALL have latency: a mask accepted at edge t yields its first beat valid in cycle t+1, and a mask with k set bits yields exactly k beats.
REQ-026 SHALL sustain one beat per cycle with ready_out held high, with no bubble between back-to-back nonzero masks.
REQ-027 SHALL, for N == 1, emit one beat with index_out = 0 and last_out = 1 per nonzero mask.
REQ-028 SHALL include a simulation assertion that onehot_out is exactly one-hot whenever valid_out is 1.

Reset
REQ-029 SHALL, while reset is high at a clock edge, set state = IDLE and pend = 0.
REQ-030 SHALL, during reset, force ready_in = 0, valid_out = 0, onehot_out = 0, index_out = 0 and last_out = 0.
REQ-031 SHALL, on reset asserted mid-mask, discard the remaining beats and present no beat after deassertion until a new mask is accepted.

Verification
REQ-032 SHALL cover: N=4, REVERSE=0, data_in=4'b1011, ready_out=1 -> onehot 0001/0010/1000, index 0/1/3, last_out high only on the third beat.
REQ-033 SHALL cover: REVERSE=1, same mask -> onehot 1000/0010/0001, index 3/1/0.
REQ-034 SHALL cover: ready_out low for 3 cycles on beat 2 -> outputs frozen, pend unchanged, ready_in=0.
REQ-035 SHALL cover: masks 4'b0110 then 4'b1000 offered continuously -> beats index 1, 2, 3 in consecutive cycles, with ready_in high during the index-2 beat.
REQ-036 SHALL cover: data_in=0 with valid_in=1 -> accepted, valid_out stays 0; then reset during the second beat of 4'b1111 -> valid_out=0 after reset and no residual beats.
